// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the two writeback sources and the register file arbiter.
// The arbiter takes the slave view; whatever drives the requests takes the master view.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
);
  logic              hold;
  logic              req0_valid;
  logic              req0_ready;
  logic [4:0]        req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [4:0]        req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic [31:0]       wren;
  logic [DATA_W-1:0] wdata;
  logic              fwd_valid;
  logic [4:0]        fwd_addr;
  logic [CNT_W-1:0]  xzr_drops;

  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wren, wdata, fwd_valid, fwd_addr, xzr_drops
  );

  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wren, wdata, fwd_valid, fwd_addr, xzr_drops
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between ALU and load writeback.
// Writes to X31 are accepted but dropped at the wren stage and counted in a saturating counter.
module regfile_wr_arbiter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [4:0]       XZR_ADDR = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic              grant0_s;
  logic              grant1_s;
  logic              xfer_s;
  logic [4:0]        sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  logic [31:0]       wren_q,      wren_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [4:0]        fwd_addr_q,  fwd_addr_d;
  logic [CNT_W-1:0]  drops_q,     drops_d;
  logic              last_q,      last_d;

  // Grant selection: a tie goes to whichever requester did not win last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (bus.hold) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      grant0_s = last_q;
      grant1_s = ~last_q;
    end else begin
      grant0_s = bus.req0_valid;
      grant1_s = bus.req1_valid;
    end
  end

  assign xfer_s     = grant0_s | grant1_s;
  assign sel_addr_s = grant1_s ? bus.req1_addr : bus.req0_addr;
  assign sel_data_s = grant1_s ? bus.req1_data : bus.req0_data;

  // Next-state for the wren stage, forwarding tap, drop counter and round-robin pointer.
  always_comb begin
    wren_d      = 32'd0;
    fwd_valid_d = 1'b0;
    wdata_d     = wdata_q;
    fwd_addr_d  = fwd_addr_q;
    drops_d     = drops_q;
    last_d      = last_q;
    if (xfer_s) begin
      wdata_d    = sel_data_s;
      fwd_addr_d = sel_addr_s;
      last_d     = grant1_s;
      if (sel_addr_s != XZR_ADDR) begin
        wren_d      = 32'd1 << sel_addr_s;
        fwd_valid_d = 1'b1;
      end else if (drops_q != CNT_MAX) begin
        drops_d = drops_q + CNT_W'(1);
      end else begin
        drops_d = drops_q;
      end
    end else begin
      last_d = last_q;
    end
  end

  // State registers; last_q resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wren_q      <= 32'd0;
      wdata_q     <= {DATA_W{1'b0}};
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= 5'd0;
      drops_q     <= {CNT_W{1'b0}};
      last_q      <= 1'b1;
    end else begin
      wren_q      <= wren_d;
      wdata_q     <= wdata_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      drops_q     <= drops_d;
      last_q      <= last_d;
    end
  end

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;
  assign bus.wren       = wren_q;
  assign bus.wdata      = wdata_q;
  assign bus.fwd_valid  = fwd_valid_q;
  assign bus.fwd_addr   = fwd_addr_q;
  assign bus.xzr_drops  = drops_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a randomized
// stream compared against a request-level reference model and a register-file array.
module tb_regfile_wr_arbiter;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  regfile_wr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.hold       = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = 5'd0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = 5'd0;
    bus.req1_data  = '0;
  endtask

  // Leaves time aligned at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    n_checks++; if (bus.wren !== 32'd0) $display("FAIL reset_wren got=%h exp=0", bus.wren); else n_pass++;
    n_checks++; if (bus.wdata !== 64'd0) $display("FAIL reset_wdata got=%h exp=0", bus.wdata); else n_pass++;
    n_checks++; if (bus.fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid got=%b exp=0", bus.fwd_valid); else n_pass++;
    n_checks++; if (bus.fwd_addr !== 5'd0) $display("FAIL reset_fwd_addr got=%0d exp=0", bus.fwd_addr); else n_pass++;
    n_checks++; if (bus.xzr_drops !== 8'd0) $display("FAIL reset_xzr got=%0d exp=0", bus.xzr_drops); else n_pass++;
    n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd5;
    bus.req0_data  = 64'hDEAD_BEEF;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) $display("FAIL single_ready got=%b exp=1", bus.req0_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_checks++; if (bus.wren !== 32'h20) $display("FAIL single_wren got=%h exp=20", bus.wren); else n_pass++;
    n_checks++; if (bus.wdata !== 64'hDEAD_BEEF) $display("FAIL single_wdata got=%h exp=deadbeef", bus.wdata); else n_pass++;
    n_checks++; if (bus.fwd_valid !== 1'b1) $display("FAIL single_fwd_valid got=%b exp=1", bus.fwd_valid); else n_pass++;
    n_checks++; if (bus.fwd_addr !== 5'd5) $display("FAIL single_fwd_addr got=%0d exp=5", bus.fwd_addr); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wren !== 32'd0) $display("FAIL single_wren_clear got=%h exp=0", bus.wren); else n_pass++;
    n_checks++; if (bus.fwd_valid !== 1'b0) $display("FAIL single_fwd_clear got=%b exp=0", bus.fwd_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_wren;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      bus.req0_data = 64'(100 + i);
      bus.req1_data = 64'(200 + i);
      #1;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      else n_pass++;
      @(posedge clk); #1;
      exp_wren = (i % 2 == 0) ? 32'h2 : 32'h4;
      n_checks++; if (bus.wren !== exp_wren) $display("FAIL b2b_wren[%0d] got=%h exp=%h", i, bus.wren, exp_wren); else n_pass++;
      n_checks++;
      if (bus.wdata !== ((i % 2 == 0) ? 64'(100 + i) : 64'(200 + i)))
        $display("FAIL b2b_wdata[%0d] got=%0d exp=%0d", i, bus.wdata, (i % 2 == 0) ? 100 + i : 200 + i);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_xzr_drop();
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd31;
    bus.req1_data  = 64'h1234;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b1) $display("FAIL xzr_ready got=%b exp=1", bus.req1_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wren !== 32'd0) $display("FAIL xzr_wren got=%h exp=0", bus.wren); else n_pass++;
    n_checks++; if (bus.fwd_valid !== 1'b0) $display("FAIL xzr_fwd_valid got=%b exp=0", bus.fwd_valid); else n_pass++;
    n_checks++; if (bus.xzr_drops !== 8'd1) $display("FAIL xzr_count1 got=%0d exp=1", bus.xzr_drops); else n_pass++;
    n_checks++; if (bus.wdata !== 64'h1234) $display("FAIL xzr_wdata got=%h exp=1234", bus.wdata); else n_pass++;
    n_checks++; if (bus.fwd_addr !== 5'd31) $display("FAIL xzr_fwd_addr got=%0d exp=31", bus.fwd_addr); else n_pass++;
    for (int i = 2; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        n_checks++;
        if (bus.xzr_drops !== 8'((i > 255) ? 255 : i))
          $display("FAIL xzr_count[%0d] got=%0d exp=%0d", i, bus.xzr_drops, (i > 255) ? 255 : i);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    bus.hold = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 64'hA;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 64'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL hold_ready[%0d] got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (bus.wren !== 32'd0) $display("FAIL hold_wren[%0d] got=%h exp=0", i, bus.wren); else n_pass++;
    end
    bus.hold = 1'b0;
    #1;
    n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL hold_release_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wren !== 32'h2) $display("FAIL hold_release_wren got=%h exp=2", bus.wren); else n_pass++;
    bus.req0_valid = 1'b0;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b1) $display("FAIL hold_next_grant got=%b exp=1", bus.req1_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.wren !== 32'h4) $display("FAIL hold_next_wren got=%h exp=4", bus.wren); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd31; bus.req1_data = 64'h5;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 64'h77;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_checks++; if (bus.wren !== 32'h80) $display("FAIL mid_wren_pre got=%h exp=80", bus.wren); else n_pass++;
    n_checks++; if (bus.xzr_drops !== 8'd1) $display("FAIL mid_xzr_pre got=%0d exp=1", bus.xzr_drops); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.wren !== 32'd0) $display("FAIL mid_wren_async got=%h exp=0", bus.wren); else n_pass++;
    n_checks++; if (bus.xzr_drops !== 8'd0) $display("FAIL mid_xzr_async got=%0d exp=0", bus.xzr_drops); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4;
    #1;
    n_checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL mid_tie_after got=%b exp=10", {bus.req0_ready, bus.req1_ready}); else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [63:0] rf_m [32];
    logic [63:0] rf_d [32];
    logic        p0, p1, h;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    int          last_w, win, w0, w1, xzr_m, bad_hot, bad_ready, bad_wait, bad_rf;
    do_reset();
    for (int i = 0; i < 32; i++) begin rf_m[i] = '0; rf_d[i] = '0; end
    p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    last_w = 1; w0 = 0; w1 = 0; xzr_m = 0;
    bad_hot = 0; bad_ready = 0; bad_wait = 0; bad_rf = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1;
        a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d0 = {$urandom, $urandom};
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1;
        a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d1 = {$urandom, $urandom};
      end
      h = ($urandom_range(0, 9) == 0);
      bus.hold = h;
      bus.req0_valid = p0; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = p1; bus.req1_addr = a1; bus.req1_data = d1;
      #1;
      if (h) win = -1;
      else if (p0 && p1) win = 1 - last_w;
      else if (p0) win = 0;
      else if (p1) win = 1;
      else win = -1;
      n_checks++;
      if (bus.req0_ready !== (win == 0) || bus.req1_ready !== (win == 1)) begin
        $display("FAIL rand_ready cyc=%0d got=%b%b exp_winner=%0d", cyc, bus.req0_ready, bus.req1_ready, win);
        bad_ready++;
      end else n_pass++;
      if (!h && p0 && win != 0) w0++;
      if (!h && p1 && win != 1) w1++;
      n_checks++;
      if (w0 > 1 || w1 > 1) begin
        $display("FAIL rand_wait cyc=%0d got=%0d/%0d exp<=1", cyc, w0, w1);
        bad_wait++;
      end else n_pass++;
      @(posedge clk);
      if (win == 0) begin
        if (a0 == 5'd31) xzr_m = (xzr_m < 255) ? xzr_m + 1 : 255; else rf_m[a0] = d0;
        p0 = 1'b0; w0 = 0; last_w = 0;
      end else if (win == 1) begin
        if (a1 == 5'd31) xzr_m = (xzr_m < 255) ? xzr_m + 1 : 255; else rf_m[a1] = d1;
        p1 = 1'b0; w1 = 0; last_w = 1;
      end
      #1;
      n_checks++;
      if (!$onehot0(bus.wren) || bus.wren[31] !== 1'b0) begin
        $display("FAIL rand_onehot cyc=%0d got=%h exp=zero_or_onehot_below31", cyc, bus.wren);
        bad_hot++;
      end else n_pass++;
      for (int r = 0; r < 32; r++) if (bus.wren[r] === 1'b1) rf_d[r] = bus.wdata;
      if (bad_hot + bad_ready + bad_wait > 20) break;
    end
    idle_inputs();
    for (int r = 0; r < 31; r++) begin
      n_checks++;
      if (rf_d[r] !== rf_m[r]) begin
        $display("FAIL rand_rf[%0d] got=%h exp=%h", r, rf_d[r], rf_m[r]);
        bad_rf++;
      end else n_pass++;
    end
    n_checks++;
    if (bus.xzr_drops !== 8'(xzr_m)) $display("FAIL rand_xzr got=%0d exp=%0d", bus.xzr_drops, xzr_m);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_xzr_drop();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
